score_keeper: RTL and testbench

Per-player score accumulator for the two-player rhythm game. It consumes the judged hit and miss pulses from each lane's timing judge and applies streak bonuses. It produces the 5-bit `result1` and `result2` scores that the winner-decision block compares. It freezes both scores once that block reports a non-zero winner code, so the final standings hold until the next round is started.

---
 rtl/score_keeper.sv | 121 ++++++++++++
 tb/tb_score_keeper.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Two-player score accumulator: counts judged hits/misses with a streak bonus,
// saturating scores, and freezes the standings once a winner code arrives.
module score_keeper #(
   parameter int SCORE_W    = 5,
   parameter int STREAK_LEN = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               hit1,
   input  logic               miss1,
   input  logic               hit2,
   input  logic               miss2,
   input  logic [1:0]         winner_in,
   output logic [SCORE_W-1:0] result1,
   output logic [SCORE_W-1:0] result2,
   output logic [2:0]         streak1,
   output logic [2:0]         streak2,
   output logic               playing,
   output logic               done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
   localparam logic [SCORE_W:0]   INC_PLAIN  = (SCORE_W+1)'(1);
   localparam logic [SCORE_W:0]   INC_BONUS  = (SCORE_W+1)'(2);
   localparam logic [2:0]         STREAK_TOP = 3'(STREAK_LEN - 1);

   state_t     state_reg;
   state_t     state_next;
   logic       clear;
   logic       score_en;
   logic [1:0] hit;
   logic [1:0] miss;

   assign hit  = {hit2, hit1};
   assign miss = {miss2, miss1};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // start overrides everything; a winner code in PLAY swallows that cycle's pulses
   always_comb begin
      state_next = state_reg;
      clear      = 1'b0;
      score_en   = 1'b0;
      if (start) begin
         state_next = PLAY;
         clear      = 1'b1;
      end else begin
         case (state_reg)
            PLAY: begin
               if (winner_in != 2'd0) begin
                  state_next = DONE;
               end else begin
                  score_en = 1'b1;
               end
            end
            default: state_next = state_reg;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_player
         logic [SCORE_W-1:0] score_reg;
         logic [SCORE_W-1:0] score_next;
         logic [2:0]         streak_reg;
         logic [2:0]         streak_next;
         logic [SCORE_W:0]   sum;

         // one extra bit on the sum catches overflow for saturation
         always_comb begin
            sum         = {1'b0, score_reg} + ((streak_reg == STREAK_TOP) ? INC_BONUS : INC_PLAIN);
            score_next  = score_reg;
            streak_next = streak_reg;
            if (clear) begin
               score_next  = '0;
               streak_next = '0;
            end else if (score_en) begin
               if (miss[gi]) begin
                  score_next  = (score_reg == '0) ? '0 : score_reg - 1'b1;
                  streak_next = '0;
               end else if (hit[gi]) begin
                  score_next  = sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
                  streak_next = (streak_reg == STREAK_TOP) ? 3'd0 : streak_reg + 3'd1;
               end
            end
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               score_reg  <= '0;
               streak_reg <= '0;
            end else begin
               score_reg  <= score_next;
               streak_reg <= streak_next;
            end
         end
      end
   endgenerate

   assign result1 = g_player[0].score_reg;
   assign result2 = g_player[1].score_reg;
   assign streak1 = g_player[0].streak_reg;
   assign streak2 = g_player[1].streak_reg;
   assign playing = (state_reg == PLAY);
   assign done    = (state_reg == DONE);

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios with literal
// expectations plus a randomized run compared cycle by cycle to a score model.
module tb_score_keeper;

   localparam int SCORE_W    = 5;
   localparam int STREAK_LEN = 4;
   localparam int SMAX       = 31;

   logic               clk       = 1'b0;
   logic               reset     = 1'b1;
   logic               start     = 1'b0;
   logic               hit1      = 1'b0;
   logic               miss1     = 1'b0;
   logic               hit2      = 1'b0;
   logic               miss2     = 1'b0;
   logic [1:0]         winner_in = 2'd0;
   logic [SCORE_W-1:0] result1;
   logic [SCORE_W-1:0] result2;
   logic [2:0]         streak1;
   logic [2:0]         streak2;
   logic               playing;
   logic               done;

   int checks   = 0;
   int failures = 0;
   bit check_en = 1'b0;

   // model: 0 = idle, 1 = play, 2 = done
   int m_state;
   int m_score [2];
   int m_streak[2];

   score_keeper #(.SCORE_W(SCORE_W), .STREAK_LEN(STREAK_LEN)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .hit1      (hit1),
      .miss1     (miss1),
      .hit2      (hit2),
      .miss2     (miss2),
      .winner_in (winner_in),
      .result1   (result1),
      .result2   (result2),
      .streak1   (streak1),
      .streak2   (streak2),
      .playing   (playing),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_player(input int p, input bit h, input bit m);
      if (m) begin
         m_score[p]  = (m_score[p] > 0) ? m_score[p] - 1 : 0;
         m_streak[p] = 0;
      end else if (h) begin
         if (m_streak[p] == STREAK_LEN - 1) begin
            m_score[p] += 2;
            m_streak[p] = 0;
         end else begin
            m_score[p] += 1;
            m_streak[p] += 1;
         end
         if (m_score[p] > SMAX) m_score[p] = SMAX;
      end
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_state = 0;
         for (int p = 0; p < 2; p++) begin
            m_score[p]  = 0;
            m_streak[p] = 0;
         end
      end else if (start) begin
         m_state = 1;
         for (int p = 0; p < 2; p++) begin
            m_score[p]  = 0;
            m_streak[p] = 0;
         end
      end else if (m_state == 1) begin
         if (winner_in != 2'd0) begin
            m_state = 2;
         end else begin
            model_player(0, hit1, miss1);
            model_player(1, hit2, miss2);
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("cmp_result1", int'(result1), m_score[0]);
         chk("cmp_result2", int'(result2), m_score[1]);
         chk("cmp_streak1", int'(streak1), m_streak[0]);
         chk("cmp_streak2", int'(streak2), m_streak[1]);
         chk("cmp_playing", int'(playing), (m_state == 1) ? 1 : 0);
         chk("cmp_done",    int'(done),    (m_state == 2) ? 1 : 0);
      end
   end

   // drive one cycle of inputs, then return 1 time unit after the sampling edge
   task automatic step(input bit h1, input bit m1, input bit h2, input bit m2,
                       input bit st, input logic [1:0] w);
      hit1      = h1;
      miss1     = m1;
      hit2      = h2;
      miss2     = m2;
      start     = st;
      winner_in = w;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_result1"}, int'(result1), 0);
      chk({tag, "_result2"}, int'(result2), 0);
      chk({tag, "_streak1"}, int'(streak1), 0);
      chk({tag, "_streak2"}, int'(streak2), 0);
      chk({tag, "_playing"}, int'(playing), 0);
      chk({tag, "_done"},    int'(done),    0);
   endtask

   int exp_steps[4] = '{1, 2, 3, 5};

   initial begin
      #1 reset = 1'b0;
      check_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      #2 reset = 1'b1;

      // idle ignores pulses
      step(1, 0, 1, 0, 0, 2'd0);
      step(1, 0, 1, 0, 0, 2'd0);
      chk("idle_result1", int'(result1), 0);
      chk("idle_playing", int'(playing), 0);

      step(0, 0, 0, 0, 1, 2'd0);
      chk("start_playing", int'(playing), 1);

      // streak bonus on the fourth hit
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0, 0, 2'd0);
         chk("streak_result1", int'(result1), exp_steps[i]);
         chk("streak_result2", int'(result2), 0);
      end
      chk("streak_end_streak1", int'(streak1), 0);

      // miss handling, starting from 5 with streak 2
      step(0, 1, 0, 0, 0, 2'd0);
      step(0, 1, 0, 0, 0, 2'd0);
      step(1, 0, 0, 0, 0, 2'd0);
      step(1, 0, 0, 0, 0, 2'd0);
      chk("pre_miss_result1", int'(result1), 5);
      chk("pre_miss_streak1", int'(streak1), 2);
      step(0, 1, 0, 0, 0, 2'd0);
      chk("miss_result1", int'(result1), 4);
      chk("miss_streak1", int'(streak1), 0);
      repeat (3) step(0, 1, 0, 0, 0, 2'd0);
      chk("miss4_result1", int'(result1), 1);
      repeat (2) step(0, 1, 0, 0, 0, 2'd0);
      chk("miss_floor_result1", int'(result1), 0);

      // simultaneous hit+miss counts as miss
      repeat (3) step(1, 0, 0, 0, 0, 2'd0);
      chk("pre_both_result1", int'(result1), 3);
      step(1, 1, 0, 0, 0, 2'd0);
      chk("both_result1", int'(result1), 2);
      chk("both_streak1", int'(streak1), 0);

      // saturation on player 2: 20 hits -> 25, 3 hits -> 28, miss -> 27, 3 hits -> 30
      repeat (23) step(0, 0, 1, 0, 0, 2'd0);
      chk("sat_pre_result2", int'(result2), 28);
      step(0, 0, 0, 1, 0, 2'd0);
      repeat (3) step(0, 0, 1, 0, 0, 2'd0);
      chk("sat30_result2", int'(result2), 30);
      chk("sat30_streak2", int'(streak2), 3);
      step(0, 0, 1, 0, 0, 2'd0);
      chk("sat_result2", int'(result2), 31);
      step(0, 0, 1, 0, 0, 2'd0);
      chk("sat_hold_result2", int'(result2), 31);
      chk("sat_p1_untouched", int'(result1), 2);

      // freeze on winner
      step(0, 0, 0, 0, 1, 2'd0);
      repeat (16) step(1, 0, 0, 0, 0, 2'd0);
      chk("freeze_pre_result1", int'(result1), 20);
      step(1, 0, 0, 0, 0, 2'd1);
      chk("freeze_done", int'(done), 1);
      chk("freeze_playing", int'(playing), 0);
      chk("freeze_result1", int'(result1), 20);
      repeat (3) step(1, 0, 1, 0, 0, 2'd0);
      step(1, 0, 1, 0, 0, 2'd2);
      chk("frozen_result1", int'(result1), 20);
      chk("frozen_result2", int'(result2), 0);
      chk("frozen_done", int'(done), 1);

      // restart from done with a concurrent hit
      step(1, 0, 0, 0, 1, 2'd0);
      chk("restart_result1", int'(result1), 0);
      chk("restart_result2", int'(result2), 0);
      chk("restart_playing", int'(playing), 1);
      chk("restart_done", int'(done), 0);
      step(1, 0, 0, 0, 0, 2'd0);
      chk("restart_next_hit", int'(result1), 1);

      // async reset mid-round with scores 7 and 9
      step(0, 0, 0, 0, 1, 2'd0);
      repeat (6) step(1, 0, 1, 0, 0, 2'd0);
      step(0, 0, 1, 0, 0, 2'd0);
      step(0, 0, 0, 1, 0, 2'd0);
      step(0, 0, 1, 0, 0, 2'd0);
      step(0, 0, 1, 0, 0, 2'd0);
      chk("mid_result1", int'(result1), 7);
      chk("mid_result2", int'(result2), 9);
      step(0, 0, 0, 0, 0, 2'd0);
      #2 reset = 1'b0;
      #1;
      chk_all_zero("async");
      #2 reset = 1'b1;
      repeat (3) step(1, 0, 1, 0, 0, 2'd0);
      chk("post_reset_result1", int'(result1), 0);
      chk("post_reset_result2", int'(result2), 0);
      chk("post_reset_playing", int'(playing), 0);
      step(0, 0, 0, 0, 1, 2'd0);
      chk("post_reset_start", int'(playing), 1);

      // randomized run against the model
      for (int n = 0; n < 3000; n++) begin
         logic [1:0] w;
         if ($urandom_range(0, 199) == 0) begin
            reset = 1'b0;
            #2;
            reset = 1'b1;
         end
         w = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 39) == 0), w);
      end

      step(0, 0, 0, 0, 0, 2'd0);
      @(negedge clk);
      #1;
      check_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
